vga_scanout: RTL and testbench

//   Display-side reader of the 640x480 12-bit framebuffer filled by the graphics

---
 rtl/vga_scanout.sv | 147 ++++++++++++++
 tb/tb_vga_scanout.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: display-side reader of the 640x480 RGB444 framebuffer.
// Generates VGA timing from a divided pixel tick, issues one synchronous
// VRAM read per visible pixel, and drives colour and syncs to the connector
// with matched two-pixel-tick latency.
// Ports:
//   clk         system clock, all logic on its rising edge
//   rstn        synchronous active-low reset
//   vram_addr   VRAM read address y*640+x, held during blanking
//   vram_data   VRAM read data {R,G,B}, valid one clk after vram_addr
//   r, g, b     colour outputs, zero outside the visible area
//   hs, vs      active-low syncs
//   vblank      high while the line counter is in vertical blanking
//   frame_start one-clk pulse after the counters wrap to (0,0)
module vga_scanout #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [18:0] vram_addr,
  input  logic [11:0] vram_data,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hs,
  output logic        vs,
  output logic        vblank,
  output logic        frame_start
);

  localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG = H_VIS + H_FP;
  localparam int unsigned HS_END = H_VIS + H_FP + H_SYNC - 1;
  localparam int unsigned VS_BEG = V_VIS + V_FP;
  localparam int unsigned VS_END = V_VIS + V_FP + V_SYNC - 1;
  localparam int unsigned DIV_W  = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic             vis_q, vis_d;
  logic             hs0_q, hs0_d;
  logic             vs0_q, vs0_d;
  logic [18:0]      addr_q, addr_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             vblank_q, vblank_d;
  logic             fs_q, fs_d;

  logic             pix_en;
  logic             h_last;
  logic             v_last;
  logic             vis0;
  logic [18:0]      addr0;

  always_comb begin
    pix_en = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    h_last = (h_cnt_q == 10'(H_TOT - 1));
    v_last = (v_cnt_q == 10'(V_TOT - 1));
    vis0   = (h_cnt_q < 10'(H_VIS)) && (v_cnt_q < 10'(V_VIS));
    // y*640 as shift-add; the framebuffer stride is fixed at 640 words
    addr0  = ({9'd0, v_cnt_q} << 9) + ({9'd0, v_cnt_q} << 7) + {9'd0, h_cnt_q};
  end

  always_comb begin
    div_cnt_d = pix_en ? '0 : div_cnt_q + 1'b1;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    vis_d     = vis_q;
    hs0_d     = hs0_q;
    vs0_d     = vs0_q;
    addr_d    = addr_q;
    rgb_d     = rgb_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    vblank_d  = vblank_q;
    fs_d      = pix_en && h_last && v_last;
    if (pix_en) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
      if (h_last) begin
        v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      end
      // Stage 0: decode current counters, launch the VRAM read
      vis_d = vis0;
      hs0_d = !((h_cnt_q >= 10'(HS_BEG)) && (h_cnt_q <= 10'(HS_END)));
      vs0_d = !((v_cnt_q >= 10'(VS_BEG)) && (v_cnt_q <= 10'(VS_END)));
      if (vis0) begin
        addr_d = addr0;
      end
      // Stage 2: read data has settled since the previous tick; syncs
      // travel through the same two registers so they stay aligned
      rgb_d    = vis_q ? vram_data : '0;
      hs_d     = hs0_q;
      vs_d     = vs0_q;
      vblank_d = (v_cnt_q >= 10'(V_VIS));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      vis_q     <= 1'b0;
      hs0_q     <= 1'b1;
      vs0_q     <= 1'b1;
      addr_q    <= '0;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      vblank_q  <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      vis_q     <= vis_d;
      hs0_q     <= hs0_d;
      vs0_q     <= vs0_d;
      addr_q    <= addr_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      vblank_q  <= vblank_d;
      fs_q      <= fs_d;
    end
  end

  assign vram_addr   = addr_q;
  assign r           = rgb_q[11:8];
  assign g           = rgb_q[7:4];
  assign b           = rgb_q[3:0];
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign vblank      = vblank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout with a reduced timing (25x13 pixel frame, 4 clk per
// pixel). Reference model derives every output from the number of pixel
// ticks elapsed since reset, using plain position arithmetic.
module tb_vga_scanout;

  localparam int CD  = 4;
  localparam int HV  = 16, HF = 2, HSY = 4, HB = 3;
  localparam int VV  = 8,  VF = 1, VSY = 2, VB = 2;
  localparam int HT  = HV + HF + HSY + HB;
  localparam int VT  = VV + VF + VSY + VB;
  localparam int FT  = HT * VT;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [18:0] vram_addr;
  logic [11:0] vram_data;
  logic [3:0]  r, g, b;
  logic        hs, vs, vblank, frame_start;

  logic [11:0] mem [0:8191];
  logic [11:0] rd_q;
  logic        force_abc = 1'b0;
  logic        abc_en = 1'b0;

  vga_scanout #(
    .CLK_DIV(CD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut (
    .clk(clk), .rstn(rstn), .vram_addr(vram_addr), .vram_data(vram_data),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .vblank(vblank),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_q <= mem[vram_addr[12:0]];
  assign vram_data = force_abc ? 12'hABC : rd_q;

  int ncmp = 0, nerr = 0;
  int t = 0, cyc = 0;
  int prev_hs = 1, prev_vs = 1, prev_fs = 0, prev_vb = 0;
  int hs_fall, hs_period, hs_width, vs_fall, vs_width;
  int fs_last, fs_period, fs_run, fs_width, vb_rise, vb_width;
  int first_hs_fall, base_cyc;

  function automatic int ph(int pos); return pos % HT; endfunction
  function automatic int pv(int pos); return pos / HT; endfunction
  function automatic bit is_vis(int pos);
    return (ph(pos) < HV) && (pv(pos) < VV);
  endfunction
  function automatic int addr_of(int h, int v); return v * 640 + h; endfunction
  // address of the most recent visible position at or before pos in a frame
  function automatic int last_addr(int pos);
    if (pv(pos) >= VV) return addr_of(HV - 1, VV - 1);
    if (ph(pos) < HV)  return addr_of(ph(pos), pv(pos));
    return addr_of(HV - 1, pv(pos));
  endfunction
  function automatic bit hs_at(int pos);
    return !((ph(pos) >= HV + HF) && (ph(pos) < HV + HF + HSY));
  endfunction
  function automatic bit vs_at(int pos);
    return !((pv(pos) >= VV + VF) && (pv(pos) < VV + VF + VSY));
  endfunction

  task automatic chk(string nm, int act, int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_meas();
    hs_fall = -1; hs_period = -1; hs_width = -1; vs_fall = -1; vs_width = -1;
    fs_last = -1; fs_period = -1; fs_run = 0; fs_width = -1;
    vb_rise = -1; vb_width = -1; first_hs_fall = -1; base_cyc = cyc;
  endtask

  task automatic step();
    int n, p1, p2, e_addr, e_rgb, e_hs, e_vs, e_vb, e_fs;
    @(posedge clk);
    if (!rstn) t = 0; else t++;
    cyc++;
    #1;
    n = t / CD;
    p1 = (n >= 1) ? (n - 1) % FT : 0;
    p2 = (n >= 2) ? (n - 2) % FT : 0;
    e_addr = (n == 0) ? 0 : last_addr(p1);
    if (n < 2) begin
      e_rgb = 0; e_hs = 1; e_vs = 1;
    end else begin
      e_rgb = is_vis(p2) ? int'(mem[addr_of(ph(p2), pv(p2))]) : 0;
      e_hs = hs_at(p2); e_vs = vs_at(p2);
    end
    e_vb = (n >= 1) && (pv(p1) >= VV);
    e_fs = (t % CD == 0) && (n >= 1) && (n % FT == 0);
    chk("vram_addr", int'(vram_addr), e_addr);
    chk("rgb", int'({r, g, b}), e_rgb);
    chk("hs", int'(hs), e_hs);
    chk("vs", int'(vs), e_vs);
    chk("vblank", int'(vblank), e_vb);
    chk("frame_start", int'(frame_start), e_fs);
    // blanking data is garbage; only affects the DUT while the staged pixel is blank
    force_abc = abc_en && !((n >= 1) && is_vis(p1));
    if (prev_hs == 1 && hs == 1'b0) begin
      if (hs_fall >= 0) hs_period = cyc - hs_fall;
      if (first_hs_fall < 0) first_hs_fall = cyc - base_cyc;
      hs_fall = cyc;
    end
    if (prev_hs == 0 && hs == 1'b1 && hs_fall >= 0) hs_width = cyc - hs_fall;
    if (prev_vs == 1 && vs == 1'b0) vs_fall = cyc;
    if (prev_vs == 0 && vs == 1'b1 && vs_fall >= 0) vs_width = cyc - vs_fall;
    if (frame_start) begin
      if (prev_fs == 0) begin
        if (fs_last >= 0) fs_period = cyc - fs_last;
        fs_last = cyc;
      end
      fs_run++;
    end else if (prev_fs == 1) begin
      fs_width = fs_run; fs_run = 0;
    end
    if (prev_vb == 0 && vblank == 1'b1) vb_rise = cyc;
    if (prev_vb == 1 && vblank == 1'b0 && vb_rise >= 0) vb_width = cyc - vb_rise;
    prev_hs = hs; prev_vs = vs; prev_fs = frame_start; prev_vb = vblank;
  endtask

  task automatic do_reset(int len);
    rstn = 1'b0;
    repeat (len) step();
    rstn = 1'b1;
  endtask

  task automatic run_to_tick(int target);
    int guard = 0;
    while ((t / CD) < target && guard < 4 * FT * CD) begin
      step(); guard++;
    end
    chk("tick_reached", t / CD, target);
  endtask

  typedef struct {
    int h; int v; int exp_addr; int exp_hs; int exp_vs; int exp_vb; int exp_vis;
  } vec_t;
  vec_t tbl[15];

  initial begin
    int k, elapsed;
    tbl[0]  = '{0,  0,  0,    1, 1, 0, 1};
    tbl[1]  = '{5,  0,  5,    1, 1, 0, 1};
    tbl[2]  = '{15, 0,  15,   1, 1, 0, 1};
    tbl[3]  = '{16, 0,  15,   1, 1, 0, 0};
    tbl[4]  = '{18, 0,  15,   0, 1, 0, 0};
    tbl[5]  = '{21, 0,  15,   0, 1, 0, 0};
    tbl[6]  = '{22, 0,  15,   1, 1, 0, 0};
    tbl[7]  = '{24, 3,  1935, 1, 1, 0, 0};
    tbl[8]  = '{3,  7,  4483, 1, 1, 0, 1};
    tbl[9]  = '{15, 7,  4495, 1, 1, 0, 1};
    tbl[10] = '{0,  8,  4495, 1, 1, 1, 0};
    tbl[11] = '{20, 9,  4495, 0, 0, 1, 0};
    tbl[12] = '{0,  10, 4495, 1, 0, 1, 0};
    tbl[13] = '{0,  11, 4495, 1, 1, 1, 0};
    tbl[14] = '{12, 12, 4495, 1, 1, 1, 0};
    for (int i = 0; i < 8192; i++) mem[i] = 12'($urandom);
    clear_meas();

    // reset held 10 clks
    do_reset(10);
    chk("rst_hs", int'(hs), 1);
    chk("rst_vs", int'(vs), 1);
    chk("rst_rgb", int'({r, g, b}), 0);
    chk("rst_addr", int'(vram_addr), 0);

    // table of positions with hand-computed expectations
    abc_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      k = tbl[i].v * HT + tbl[i].h + 1;
      run_to_tick(k);
      chk($sformatf("tbl%0d_addr", i), int'(vram_addr), tbl[i].exp_addr);
      chk($sformatf("tbl%0d_vblank", i), int'(vblank), tbl[i].exp_vb);
      run_to_tick(k + 1);
      chk($sformatf("tbl%0d_hs", i), int'(hs), tbl[i].exp_hs);
      chk($sformatf("tbl%0d_vs", i), int'(vs), tbl[i].exp_vs);
      chk($sformatf("tbl%0d_rgb", i), int'({r, g, b}),
          tbl[i].exp_vis ? int'(mem[tbl[i].exp_addr]) : 0);
    end

    // sync / pulse widths and periods over three frames
    do_reset(2);
    clear_meas();
    repeat (3 * FT * CD) step();
    chk("first_hs_fall", first_hs_fall, (HV + HF + 2) * CD);
    chk("hs_width", hs_width, HSY * CD);
    chk("hs_period", hs_period, HT * CD);
    chk("vs_width", vs_width, VSY * HT * CD);
    chk("fs_period", fs_period, FT * CD);
    chk("fs_width", fs_width, 1);
    chk("vblank_width", vb_width, (VT - VV) * HT * CD);

    // one-clk reset mid-frame at (10,4)
    run_to_tick(4 * HT + 10 + 1 + FT * ((t / CD) / FT + 1));
    do_reset(1);
    chk("mid_rst_addr", int'(vram_addr), 0);
    chk("mid_rst_hs", int'(hs), 1);
    chk("mid_rst_vb", int'(vblank), 0);
    elapsed = 0;
    while (frame_start !== 1'b1 && elapsed < 2 * FT * CD) begin
      step(); elapsed++;
    end
    chk("mid_rst_fs_delay", elapsed, FT * CD);

    // randomized segments with occasional resets and garbage blanking data
    for (int s = 0; s < 6; s++) begin
      abc_en = 1'($urandom);
      repeat ($urandom_range(200, 1500)) step();
      if ($urandom_range(0, 1) == 1) do_reset($urandom_range(1, 3));
    end
    repeat (FT * CD) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
